// File: rtl/snitch_l0_tlb.sv
// Fully-associative L0 TLB in front of the Sv32 page table walker.
// One translation in flight; misses walk via the PTW and fill a victim entry.
module snitch_l0_tlb #(
  parameter int unsigned AddrWidth  = 34,
  parameter int unsigned PageShift  = 12,
  parameter int unsigned VpnSize    = 10,
  parameter int unsigned NumEntries = 4,
  parameter int unsigned PPNSize    = AddrWidth - PageShift
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [31:0]        req_va_i,
  input  logic               req_write_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [PPNSize-1:0] rsp_ppn_o,
  output logic [5:0]         rsp_flags_o,
  output logic               rsp_fault_o,
  output logic               ptw_valid_o,
  input  logic               ptw_ready_i,
  output logic [31:0]        ptw_va_o,
  input  logic [PPNSize-1:0] ptw_pa_i,
  input  logic [5:0]         ptw_flags_i,
  input  logic               ptw_is_4mega_i
);

  localparam int unsigned PtrW = (NumEntries > 1) ? $clog2(NumEntries) : 1;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StLookup  = 2'd1;
  localparam logic [1:0] StRefill  = 2'd2;
  localparam logic [1:0] StRespond = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [31:0]        va_q;
  logic               write_q;
  logic [PPNSize-1:0] rsp_ppn_q, rsp_ppn_d;
  logic [5:0]         rsp_flags_q, rsp_flags_d;
  logic               rsp_fault_q, rsp_fault_d;
  logic               req_accept, rsp_load, fill_en;

  logic [NumEntries-1:0] valid_q;
  logic [NumEntries-1:0] e_mega_q;
  logic [VpnSize-1:0]    e_vpn1_q  [NumEntries];
  logic [VpnSize-1:0]    e_vpn0_q  [NumEntries];
  logic [PPNSize-1:0]    e_ppn_q   [NumEntries];
  logic [5:0]            e_flags_q [NumEntries];
  logic [PtrW-1:0]       rr_q;

  logic [VpnSize-1:0]    va_vpn1, va_vpn0;
  logic [NumEntries-1:0] hit;
  logic                  hit_any, hit_mega;
  logic [PPNSize-1:0]    hit_ppn;
  logic [5:0]            hit_flags;
  logic [PtrW-1:0]       victim;
  logic                  inv_found;

  assign va_vpn1 = va_q[31 -: VpnSize];
  assign va_vpn0 = va_q[PageShift +: VpnSize];

  // Superpages take the low PPN bits straight from the VA.
  function automatic logic [PPNSize-1:0] compose_ppn(input logic [PPNSize-1:0] ppn,
                                                     input logic mega,
                                                     input logic [VpnSize-1:0] vpn0);
    return mega ? {ppn[PPNSize-1:VpnSize], vpn0} : ppn;
  endfunction

  function automatic logic calc_fault(input logic [5:0] flags, input logic write);
    return !flags[4] || (write && !flags[1]) || (!write && !flags[0]);
  endfunction

  always_comb begin
    hit       = '0;
    hit_ppn   = '0;
    hit_flags = '0;
    hit_mega  = 1'b0;
    for (int unsigned i = 0; i < NumEntries; i++) begin
      hit[i] = valid_q[i] && (e_vpn1_q[i] == va_vpn1) &&
               (e_mega_q[i] || (e_vpn0_q[i] == va_vpn0));
      if (hit[i]) begin
        hit_ppn   = e_ppn_q[i];
        hit_flags = e_flags_q[i];
        hit_mega  = e_mega_q[i];
      end
    end
    hit_any = (|hit) && !flush_i;
  end

  // Lowest-index invalid entry wins; otherwise fall back to round-robin.
  always_comb begin
    victim    = rr_q;
    inv_found = 1'b0;
    for (int i = NumEntries - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        victim    = PtrW'(i);
        inv_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_accept  = 1'b0;
    rsp_load    = 1'b0;
    fill_en     = 1'b0;
    rsp_ppn_d   = rsp_ppn_q;
    rsp_flags_d = rsp_flags_q;
    rsp_fault_d = rsp_fault_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          req_accept = 1'b1;
          state_d    = StLookup;
        end
      end
      StLookup: begin
        if (hit_any) begin
          rsp_load    = 1'b1;
          rsp_ppn_d   = compose_ppn(hit_ppn, hit_mega, va_vpn0);
          rsp_flags_d = hit_flags;
          rsp_fault_d = calc_fault(hit_flags, write_q);
          state_d     = StRespond;
        end else begin
          state_d = StRefill;
        end
      end
      StRefill: begin
        if (ptw_ready_i) begin
          rsp_load    = 1'b1;
          rsp_ppn_d   = compose_ppn(ptw_pa_i, ptw_is_4mega_i, va_vpn0);
          rsp_flags_d = ptw_flags_i;
          rsp_fault_d = calc_fault(ptw_flags_i, write_q);
          fill_en     = ptw_flags_i[4] && !flush_i;
          state_d     = StRespond;
        end
      end
      StRespond: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      va_q        <= '0;
      write_q     <= 1'b0;
      rsp_ppn_q   <= '0;
      rsp_flags_q <= '0;
      rsp_fault_q <= 1'b0;
      valid_q     <= '0;
      rr_q        <= '0;
    end else begin
      state_q <= state_d;
      if (req_accept) begin
        va_q    <= req_va_i;
        write_q <= req_write_i;
      end
      if (rsp_load) begin
        rsp_ppn_q   <= rsp_ppn_d;
        rsp_flags_q <= rsp_flags_d;
        rsp_fault_q <= rsp_fault_d;
      end
      if (flush_i) begin
        valid_q <= '0;
      end else if (fill_en) begin
        valid_q[victim] <= 1'b1;
      end
      if (fill_en && !inv_found) begin
        rr_q <= (rr_q == PtrW'(NumEntries - 1)) ? '0 : rr_q + 1'b1;
      end
    end
  end

  // Entry payload needs no reset; valid_q guards it.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      e_vpn1_q[victim]  <= va_vpn1;
      e_vpn0_q[victim]  <= va_vpn0;
      e_mega_q[victim]  <= ptw_is_4mega_i;
      e_ppn_q[victim]   <= ptw_pa_i;
      e_flags_q[victim] <= ptw_flags_i;
    end
  end

  assign req_ready_o = !rst_i && (state_q == StIdle);
  assign rsp_valid_o = !rst_i && (state_q == StRespond);
  assign ptw_valid_o = !rst_i && (state_q == StRefill);
  assign ptw_va_o    = rst_i ? '0 : va_q;
  assign rsp_ppn_o   = rst_i ? '0 : rsp_ppn_q;
  assign rsp_flags_o = rst_i ? '0 : rsp_flags_q;
  assign rsp_fault_o = rst_i ? 1'b0 : rsp_fault_q;

  ptw_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
    ptw_valid_o && !ptw_ready_i |=> ptw_valid_o && $stable(ptw_va_o));

  rsp_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_valid_o && !rsp_ready_i |=> rsp_valid_o && $stable(rsp_ppn_o) &&
                                    $stable(rsp_flags_o) && $stable(rsp_fault_o));

  hit_onehot_a: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(hit));

endmodule

// File: tb/tb_snitch_l0_tlb.sv
// Bench for snitch_l0_tlb: directed scenarios then random traffic, checked against
// an associative-array style reference of the TLB contents.
module tb_snitch_l0_tlb;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, req_valid_i, req_ready_o, req_write_i;
  logic [31:0] req_va_i, ptw_va_o;
  logic        rsp_valid_o, rsp_ready_i, rsp_fault_o, ptw_valid_o, ptw_ready_i, ptw_is_4mega_i;
  logic [21:0] rsp_ppn_o, ptw_pa_i;
  logic [5:0]  rsp_flags_o, ptw_flags_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  snitch_l0_tlb dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_va_i       (req_va_i),
    .req_write_i    (req_write_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_ppn_o      (rsp_ppn_o),
    .rsp_flags_o    (rsp_flags_o),
    .rsp_fault_o    (rsp_fault_o),
    .ptw_valid_o    (ptw_valid_o),
    .ptw_ready_i    (ptw_ready_i),
    .ptw_va_o       (ptw_va_o),
    .ptw_pa_i       (ptw_pa_i),
    .ptw_flags_i    (ptw_flags_i),
    .ptw_is_4mega_i (ptw_is_4mega_i)
  );

  typedef struct {
    bit        v;
    bit [9:0]  vpn1;
    bit [9:0]  vpn0;
    bit        mega;
    bit [21:0] ppn;
    bit [5:0]  fl;
  } ent_t;

  ent_t m[4];
  int   rr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_find(input bit [31:0] va);
    for (int i = 0; i < 4; i++)
      if (m[i].v && m[i].vpn1 == va[31:22] && (m[i].mega || m[i].vpn0 == va[21:12])) return i;
    return -1;
  endfunction

  task automatic m_flush();
    for (int i = 0; i < 4; i++) m[i].v = 0;
  endtask

  task automatic m_reset();
    m_flush();
    rr = 0;
  endtask

  task automatic m_fill(input bit [31:0] va, input bit [21:0] pa, input bit [5:0] fl,
                        input bit mega);
    int slot = -1;
    for (int i = 3; i >= 0; i--) if (!m[i].v) slot = i;
    if (slot < 0) begin
      slot = rr;
      rr   = (rr + 1) % 4;
    end
    m[slot] = '{v: 1, vpn1: va[31:22], vpn0: va[21:12], mega: mega, ppn: pa, fl: fl};
  endtask

  task automatic access(input logic [31:0] va, input logic wr, input logic [21:0] pa,
                        input logic [5:0] fl, input logic mega, input int dly,
                        input logic fl_lk, input logic fl_rf, input int hold,
                        input logic rst_rf);
    int          idx;
    logic        exp_hit, ef;
    logic [21:0] eppn;
    logic [5:0]  efl;
    check("idle_ready", req_ready_o, 1);
    req_valid_i = 1; req_va_i = va; req_write_i = wr;
    @(negedge clk);
    req_valid_i = 0; req_va_i = $urandom; req_write_i = $urandom;
    check("lookup_ready", req_ready_o, 0);
    check("lookup_no_ptw", ptw_valid_o, 0);
    check("lookup_no_rsp", rsp_valid_o, 0);
    idx     = m_find(va);
    exp_hit = (idx >= 0) && !fl_lk;
    flush_i = fl_lk;
    @(negedge clk);
    flush_i = 0;
    if (fl_lk) m_flush();
    if (exp_hit) begin
      eppn = m[idx].mega ? {m[idx].ppn[21:10], va[21:12]} : m[idx].ppn;
      efl  = m[idx].fl;
      check("hit_rsp_valid", rsp_valid_o, 1);
      check("hit_no_ptw", ptw_valid_o, 0);
    end else begin
      check("miss_ptw_valid", ptw_valid_o, 1);
      check("miss_ptw_va", ptw_va_o, va);
      check("miss_no_rsp", rsp_valid_o, 0);
      if (rst_rf) begin
        rst_i = 1;
        @(negedge clk);
        check("rst_ptw_valid", ptw_valid_o, 0);
        check("rst_req_ready", req_ready_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_ptw_va", ptw_va_o, 0);
        rst_i = 0;
        m_reset();
        @(negedge clk);
        check("post_rst_ready", req_ready_o, 1);
        check("post_rst_ptw", ptw_valid_o, 0);
        return;
      end
      repeat (dly) begin
        @(negedge clk);
        check("ptw_hold_valid", ptw_valid_o, 1);
        check("ptw_hold_va", ptw_va_o, va);
        check("ptw_hold_no_rsp", rsp_valid_o, 0);
      end
      ptw_ready_i = 1; ptw_pa_i = pa; ptw_flags_i = fl; ptw_is_4mega_i = mega; flush_i = fl_rf;
      @(negedge clk);
      ptw_ready_i = 0; ptw_pa_i = $urandom; ptw_flags_i = $urandom; ptw_is_4mega_i = $urandom;
      flush_i = 0;
      eppn = mega ? {pa[21:10], va[21:12]} : pa;
      efl  = fl;
      if (fl_rf) m_flush();
      else if (fl[4]) m_fill(va, pa, fl, mega);
      check("miss_rsp_valid", rsp_valid_o, 1);
      check("miss_ptw_dropped", ptw_valid_o, 0);
    end
    ef = !efl[4] || (wr && !efl[1]) || (!wr && !efl[0]);
    check("rsp_ppn", rsp_ppn_o, eppn);
    check("rsp_flags", rsp_flags_o, efl);
    check("rsp_fault", rsp_fault_o, ef);
    repeat (hold) begin
      @(negedge clk);
      check("bp_valid", rsp_valid_o, 1);
      check("bp_req_ready", req_ready_o, 0);
      check("bp_ppn", rsp_ppn_o, eppn);
      check("bp_flags", rsp_flags_o, efl);
      check("bp_fault", rsp_fault_o, ef);
    end
    rsp_ready_i = 1;
    @(negedge clk);
    rsp_ready_i = 0;
    check("back_idle", req_ready_o, 1);
    check("idle_no_rsp", rsp_valid_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [5:0] FlR   = 6'b010001;
  localparam logic [5:0] FlRw  = 6'b110011;
  localparam logic [5:0] FlBad = 6'b000011;

  initial begin
    logic [31:0] va;
    logic [9:0]  v1;
    logic [5:0]  fl;
    rst_i = 1; flush_i = 0; req_valid_i = 0; req_va_i = 0; req_write_i = 0;
    rsp_ready_i = 0; ptw_ready_i = 0; ptw_pa_i = 0; ptw_flags_i = 0; ptw_is_4mega_i = 0;
    m_reset();
    repeat (3) @(negedge clk);
    check("reset_req_ready", req_ready_o, 0);
    check("reset_rsp_valid", rsp_valid_o, 0);
    check("reset_ptw_valid", ptw_valid_o, 0);
    check("reset_rsp_ppn", rsp_ppn_o, 0);
    check("reset_ptw_va", ptw_va_o, 0);
    rst_i = 0;
    @(negedge clk);

    // Cold miss, then the same VA hits.
    access(32'h0040_1123, 0, 22'h00ABC, FlR, 0, 2, 0, 0, 0, 0);
    access(32'h0040_1123, 0, 22'h3FFFF, FlRw, 0, 0, 0, 0, 0, 0);
    // Superpage fill, then a hit inside it.
    access(32'h0080_0000, 0, 22'h00C00, FlRw, 1, 1, 0, 0, 0, 0);
    access(32'h0083_F000, 0, 22'h00000, FlR, 0, 0, 0, 0, 0, 0);
    check("superpage_ppn_literal", rsp_ppn_o, 22'h00C3F);
    // Store to a read-only page, then a walk returning a=0 twice.
    access(32'h0040_1123, 1, 22'h0, FlR, 0, 0, 0, 0, 0, 0);
    access(32'h0140_5000, 0, 22'h00123, FlBad, 0, 1, 0, 0, 0, 0);
    access(32'h0140_5000, 0, 22'h00123, FlBad, 0, 0, 0, 0, 0, 0);

    // Idle flush, then fill all four slots and one more.
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    m_flush();
    check("flush_idle_ready", req_ready_o, 1);
    for (int p = 1; p <= 5; p++)
      access(32'h00C0_0000 | (p << 12), 0, 22'h01000 + p, FlRw, 0, p % 3, 0, 0, 0, 0);
    for (int p = 2; p <= 4; p++)
      access(32'h00C0_0000 | (p << 12), 0, 22'h0, FlRw, 0, 0, 0, 0, 0, 0);
    access(32'h00C0_1000, 0, 22'h02001, FlRw, 0, 1, 0, 0, 0, 0);

    // Flush in the PTW-ready cycle, then flush in Lookup of a resident VA.
    access(32'h0180_7000, 0, 22'h00777, FlRw, 0, 1, 0, 1, 0, 0);
    access(32'h0180_7000, 0, 22'h00778, FlRw, 0, 0, 0, 0, 0, 0);
    access(32'h0180_7000, 0, 22'h00779, FlRw, 0, 2, 1, 0, 0, 0);

    // Backpressure on a hit, then reset in the middle of a walk.
    access(32'h0180_7ABC, 1, 22'h0, FlRw, 0, 0, 0, 0, 5, 0);
    access(32'h01C0_8000, 0, 22'h00888, FlRw, 0, 0, 0, 0, 0, 1);
    access(32'h0180_7000, 0, 22'h0077A, FlR, 0, 1, 0, 0, 2, 0);

    // Random traffic; vpn1 9 is always a superpage so translations stay consistent.
    for (int n = 0; n < 80; n++) begin
      v1 = 10'(8 + $urandom_range(0, 2));
      va = {v1, 10'($urandom_range(0, 3)), 12'($urandom)};
      fl = 6'($urandom);
      fl[4] = ($urandom_range(0, 5) != 0);
      access(va, 1'($urandom), 22'($urandom), fl, v1 == 10'd9, $urandom_range(0, 3),
             $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snitch_l0_tlb.md
Name: snitch_l0_tlb

Overview:
- Small fully-associative L0 TLB that sits directly upstream of the Sv32 page table walker.
- It accepts one virtual-address translation request at a time from a core-side port.
- On a miss it issues the walk request to the PTW, fills an entry from the returned PTE, then returns the physical page number and flags.
- It checks permissions for read or write accesses and reports page faults.

Parameters:
- AddrWidth, 34, physical address width.
- PageShift, 12, page offset bits.
- VpnSize, 10, bits per VPN level. PageShift + 2*VpnSize must equal 32.
- NumEntries, 4, number of TLB entries (>=1).
- PPNSize, AddrWidth-PageShift, derived, do not change. ppn0 is the low VpnSize bits; ppn1 is the remaining upper bits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  invalidate all entries (sfence.vma)
- req_valid_i  in  1  translation request valid
- req_ready_o  out  1  request accepted
- req_va_i  in  32  virtual address {vpn1, vpn0, offset}
- req_write_i  in  1  1 = store access, 0 = load access
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_ppn_o  out  PPNSize  translated PPN
- rsp_flags_o  out  6  {d, a, u, x, w, r} of the translating PTE
- rsp_fault_o  out  1  page fault
- ptw_valid_o  out  1  walk request, held until ptw_ready_i
- ptw_ready_i  in  1  walk done; PTE inputs valid in this cycle only
- ptw_va_o  out  32  virtual address to walk (latched VA)
- ptw_pa_i  in  PPNSize  PTE physical page number
- ptw_flags_i  in  6  PTE flags {d, a, u, x, w, r}; a=0 means invalid or error
- ptw_is_4mega_i  in  1  PTE is a 4 MiB superpage

Behaviour:
- States: Idle, Lookup, Refill, Respond. Reset forces Idle, clears all entry valid bits, and clears the round-robin pointer to 0.
- While rst_i=1: req_ready_o=0, rsp_valid_o=0, ptw_valid_o=0. All data outputs are 0.
- Idle:
  - req_ready_o=1.
  - On req_valid_i: latch va and write, then go to Lookup.
- Lookup (one cycle), using the latched VA:
  - Entry i hits when valid_i && vpn1==e.vpn1 && (e.is_4mega || vpn0==e.vpn0).
  - Hit: latch the response, go to Respond.
  - Miss: go to Refill.
  - If flush_i=1 in this cycle, the hit is suppressed and the access is treated as a miss.
- Refill:
  - ptw_valid_o=1 and ptw_va_o=latched VA, held stable until ptw_ready_i.
  - On ptw_ready_i: latch the response from the PTW inputs, then go to Respond.
  - Fill an entry only when ptw_flags_i.a=1 and flush_i=0 in that cycle.
  - Victim: lowest-index invalid entry if any; otherwise the round-robin pointer, which then increments modulo NumEntries. The pointer is untouched when an invalid entry is used.
  - A flush during Refill does not abort the walk. The result is still returned but not filled.
- Respond:
  - rsp_valid_o=1; all rsp_* held stable until rsp_ready_i, then go to Idle.
  - req_ready_o=0 in every state except Idle.
- PPN composition:
  - Superpage: rsp_ppn_o = {e.ppn1, va.vpn0}.
  - Otherwise: rsp_ppn_o = e.pa.
- Fault: rsp_fault_o = !a || (write && !w) || (!write && !r).
- Latency:
  - Hit: request accepted in cycle T, rsp_valid_o in T+2.
  - Miss: rsp_valid_o in the cycle after ptw_ready_i.
- Entries are only filled on a miss, so duplicate entries cannot occur.
- flush_i in any state clears all valid bits on the next edge; the pointer is not reset.
- rsp_ready_i may already be high when rsp_valid_o rises. The transfer then completes in that cycle.
- Assertions:
  - ptw_valid_o && !ptw_ready_i implies ptw_valid_o and ptw_va_o stable next cycle.
  - rsp_valid_o && !rsp_ready_i implies rsp_* stable next cycle.
  - At most one entry hits.

Test Plan:
1. Cold miss then hit:
   - Read va 0x0040_1123 (vpn1=1, vpn0=1); PTW returns pa=0x00ABC, flags a=1 r=1 w=0, 4mega=0.
   - Response: ppn 0x00ABC, fault 0, ptw_valid_o high until ready.
   - The same VA again gives a hit: rsp_valid_o exactly 2 cycles after acceptance, ptw_valid_o never asserted.
2. Superpage:
   - Fill va 0x0080_0000 with 4mega=1, pa=0x00C00; then read va 0x0083_F000 (vpn1=2, vpn0=0x3F).
   - Result: hit, ppn 0x00C3F.
3. Permission and invalid:
   - Write to the page from scenario 1: fault=1 with no PTW request.
   - Walk returning a=0: fault=1, not filled; a repeat of the same VA walks again.
4. Replacement with NumEntries=4:
   - Fill 4 distinct pages, then a 5th: it evicts entry 0 (pointer 0 becomes 1).
   - Page 1 misses; pages 2-4 hit.
5. Flush:
   - flush_i during Refill: the response is still delivered, but the next request to the same VA misses.
   - flush_i in the Lookup cycle of a resident VA: treated as a miss, and the PTW is requested.
6. Backpressure and reset:
   - Hold rsp_ready_i=0 for 5 cycles: outputs stable, req_ready_o=0.
   - Assert rst_i mid-Refill: next cycle Idle, ptw_valid_o=0, all entries miss.
